gray_pointer_sync: RTL and testbench
====================================

// Module: gray_pointer_sync
// PURPOSE
//  Receives a Gray-coded counter/pointer from another clock domain, synchronises it into clk
//  through a multi-flop chain, converts it to binary and reports steps between values.
//  Sits directly downstream of binaryToGrayConverter; a bus-validity checker flags any sampled
//  transition that changes more than one Gray bit.
// PARAMETERS
//  WIDTH        4  pointer width in bits (>=2)
//  SYNC_STAGES  2  synchroniser flops on gray_in (>=2)
// PORTS
//  clk            in   1      single clock; all flops rising-edge
//  rst            in   1      asynchronous, active-high reset
//  gray_in        in   WIDTH  Gray-coded pointer from foreign domain (async to clk)
//  err_clear      in   1      clears err_sticky
//  gray_sync      out  WIDTH  last synchroniser stage (raw, for debug)
//  bin_out        out  WIDTH  binary value of last accepted Gray sample
//  changed        out  1      1-cycle pulse: bin_out updated this cycle
//  step           out  WIDTH  (new_bin - old_bin) mod 2^WIDTH, valid with changed
//  multi_bit_err  out  1      1-cycle pulse: accepted transition changed >1 Gray bit
//  err_sticky     out  1      latched OR of multi_bit_err until err_clear
// BEHAVIOUR
//  - Reset (async assert, sync release): sync chain, gray_prev, bin_out, step = 0;
//    changed, multi_bit_err, err_sticky = 0; FSM -> PRIME, prime counter = 0.
//  - Sync chain: s[0]<=gray_in; s[i]<=s[i-1]; gray_sync = s[SYNC_STAGES-1]. No other logic on s[0].
//  - Conversion: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i]. Combinational on gray_sync, then registered.
//  - FSM PRIME: counts SYNC_STAGES cycles after reset release (chain filled with real data);
//    on the edge ending PRIME: gray_prev<=gray_sync, bin_out<=g2b(gray_sync), step stays 0,
//    changed/multi_bit_err NOT asserted; -> TRACK.
//  - FSM TRACK, each edge with gray_sync != gray_prev:
//    gray_prev<=gray_sync; bin_out<=g2b(gray_sync); step<=g2b(gray_sync)-bin_out (WIDTH-bit wrap);
//    changed<=1; multi_bit_err<=(popcount(gray_sync^gray_prev)>1); err_sticky set if so.
//    Edges with gray_sync == gray_prev: changed, multi_bit_err <=0; bin_out, step hold.
//  - bin_out updates even on an erroneous transition (value taken as-is, error only reported).
//  - Latency (TRACK): gray_in stable before edge k -> bin_out/changed valid after edge k+SYNC_STAGES.
//  - Wrap-around: gray 100..0 -> 000..0 is a legal single-bit step; step=1, no error.
//  - err_clear and a new multi_bit_err on the same edge: set wins, err_sticky stays 1.
//  - Reset mid-operation: all outputs drop to reset values immediately; re-enter PRIME, no
//    changed pulse for the value present at release.
//  - changed is a single-cycle pulse; consecutive edges may each pulse if gray_sync keeps moving.
// TESTING (WIDTH=4, SYNC_STAGES=2)
//  1 rst high, gray_in=0110, release -> changed never pulses; bin_out=0100 by end of PRIME, err=0.
//  2 walk gray_in through gray(0..15) every 10 cycles from 0000 -> 16 changed pulses, bin_out=0..15,
//    step=0001 each, multi_bit_err never set.
//  3 wrap: gray_in 1000 -> 0000 -> bin_out 1111 -> 0000, step=0001, no error.
//  4 gray_in 0000 -> 0011 in TRACK -> bin_out=0010, step=0010, multi_bit_err 1-cycle pulse,
//    err_sticky=1; err_clear alone -> 0; err_clear coincident with new error -> stays 1.
//  5 latency: change gray_in 0000->0001 just before edge k -> changed high after edge k+2, not k+1.
//  6 assert rst mid-walk (bin_out=0111) -> all outputs 0 same cycle; release with gray_in=0101 ->
//    PRIME, bin_out=0110, no changed pulse.

Source files
------------

// File: rtl/gray_pointer_sync.sv
// Gray-coded pointer synchroniser: multi-flop capture of a foreign-domain Gray pointer,
// Gray-to-binary conversion, step reporting and detection of illegal multi-bit transitions.
module gray_pointer_sync #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clear,
  output logic [WIDTH-1:0] gray_sync,
  output logic [WIDTH-1:0] bin_out,
  output logic             changed,
  output logic [WIDTH-1:0] step,
  output logic             multi_bit_err,
  output logic             err_sticky
);

  localparam int unsigned CntW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [0:0] {StPrime, StTrack} state_e;

  state_e           state_q;
  logic [CntW-1:0]  prime_cnt_q;
  logic [WIDTH-1:0] gray_prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  logic [WIDTH-1:0] bin_sync;
  logic [WIDTH-1:0] gray_diff;
  logic             accept;
  logic             bad_step;

  // Pure flop chain; the first stage sees gray_in directly and nothing else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign gray_sync = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_sync = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin_sync[i] = ^(gray_sync >> i);
    end
  end

  always_comb begin
    gray_diff = gray_sync ^ gray_prev_q;
    accept    = (state_q == StTrack) && (gray_diff != '0);
    // More than one bit set <=> clearing the lowest set bit leaves something behind.
    bad_step  = accept && (|(gray_diff & (gray_diff - WIDTH'(1))));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StPrime;
      prime_cnt_q   <= '0;
      gray_prev_q   <= '0;
      bin_out       <= '0;
      step          <= '0;
      changed       <= 1'b0;
      multi_bit_err <= 1'b0;
      err_sticky    <= 1'b0;
    end else begin
      changed       <= 1'b0;
      multi_bit_err <= 1'b0;

      // A fresh error outranks a simultaneous clear.
      if (bad_step) begin
        err_sticky <= 1'b1;
      end else if (err_clear) begin
        err_sticky <= 1'b0;
      end

      unique case (state_q)
        StPrime: begin
          if (prime_cnt_q == CntW'(SYNC_STAGES)) begin
            gray_prev_q <= gray_sync;
            bin_out     <= bin_sync;
            state_q     <= StTrack;
          end else begin
            prime_cnt_q <= prime_cnt_q + CntW'(1);
          end
        end
        StTrack: begin
          if (accept) begin
            gray_prev_q   <= gray_sync;
            bin_out       <= bin_sync;
            step          <= bin_sync - bin_out;
            changed       <= 1'b1;
            multi_bit_err <= bad_step;
          end
        end
        default: state_q <= StPrime;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_pointer_sync.sv
// Directed bench for gray_pointer_sync with a per-cycle reference model built from
// a delayed-sample queue and arithmetic Gray decoding.
module tb_gray_pointer_sync;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         err_clear;
  logic [W-1:0] gray_in;
  logic [W-1:0] gray_sync;
  logic [W-1:0] bin_out;
  logic         changed;
  logic [W-1:0] step;
  logic         multi_bit_err;
  logic         err_sticky;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  int err_cnt   = 0;

  always #5 clk = ~clk;

  gray_pointer_sync #(
    .WIDTH       (W),
    .SYNC_STAGES (S)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .gray_in       (gray_in),
    .err_clear     (err_clear),
    .gray_sync     (gray_sync),
    .bin_out       (bin_out),
    .changed       (changed),
    .step          (step),
    .multi_bit_err (multi_bit_err),
    .err_sticky    (err_sticky)
  );

  function automatic logic [W-1:0] to_gray(input int v);
    return W'(v ^ (v >> 1));
  endfunction

  // Decode by search: the binary value whose Gray code matches.
  function automatic logic [W-1:0] to_bin(input logic [W-1:0] g);
    for (int v = 0; v < (1 << W); v++) begin
      if (to_gray(v) == g) return W'(v);
    end
    return '0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [W-1:0] hist[$];
  logic [W-1:0] m_gsync   = '0;
  logic [W-1:0] m_bin     = '0;
  logic [W-1:0] m_step    = '0;
  logic [W-1:0] m_prev    = '0;
  logic         m_changed = 1'b0;
  logic         m_err     = 1'b0;
  logic         m_sticky  = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        hist.delete();
        m_gsync = '0; m_bin = '0; m_step = '0; m_prev = '0;
        m_changed = 1'b0; m_err = 1'b0; m_sticky = 1'b0;
      end else begin
        automatic int n = hist.size();
        automatic logic [W-1:0] g = (n >= S) ? hist[n-S] : '0;
        m_changed = 1'b0;
        m_err     = 1'b0;
        if (n == S) begin
          m_prev = g;
          m_bin  = to_bin(g);
        end else if (n > S && g != m_prev) begin
          m_step    = to_bin(g) - m_bin;
          m_bin     = to_bin(g);
          m_changed = 1'b1;
          m_err     = ($countones(g ^ m_prev) > 1);
          m_prev    = g;
        end
        if (m_err) m_sticky = 1'b1;
        else if (err_clear) m_sticky = 1'b0;
        hist.push_back(gray_in);
        m_gsync = (hist.size() >= S) ? hist[hist.size()-S] : '0;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      check("gray_sync", 32'(gray_sync), 32'(m_gsync));
      check("bin_out", 32'(bin_out), 32'(m_bin));
      check("changed", 32'(changed), 32'(m_changed));
      check("step", 32'(step), 32'(m_step));
      check("multi_bit_err", 32'(multi_bit_err), 32'(m_err));
      check("err_sticky", 32'(err_sticky), 32'(m_sticky));
      if (changed === 1'b1) pulse_cnt++;
      if (multi_bit_err === 1'b1) err_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int p0;
  int e0;

  initial begin
    rst = 1'b1; gray_in = 4'b0110; err_clear = 1'b0;
    repeat (3) tick();

    // Priming: value present at release is adopted silently
    p0 = pulse_cnt;
    rst = 1'b0;
    repeat (10) tick();
    check("t1_bin", 32'(bin_out), 32'h4);
    check("t1_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("t1_sticky", 32'(err_sticky), 32'd0);

    // Full walk through all codes, ending with the wrap back to zero
    rst = 1'b1; gray_in = 4'b0000;
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    p0 = pulse_cnt; e0 = err_cnt;
    for (int v = 1; v <= 16; v++) begin
      gray_in = to_gray(v % 16);
      repeat (10) tick();
      check("t2_bin", 32'(bin_out), 32'(v % 16));
      check("t2_step", 32'(step), 32'd1);
    end
    check("t2_pulses", 32'(pulse_cnt - p0), 32'd16);
    check("t2_errs", 32'(err_cnt - e0), 32'd0);

    // Latency: change just before edge k, pulse only after edge k+2
    gray_in = 4'b0001;
    @(posedge clk); #1;
    check("t5_k", 32'(changed), 32'd0);
    @(posedge clk); #1;
    check("t5_k1", 32'(changed), 32'd0);
    @(posedge clk); #1;
    check("t5_k2", 32'(changed), 32'd1);
    check("t5_bin", 32'(bin_out), 32'd1);

    // Illegal two-bit transition and sticky clear behaviour
    repeat (5) tick();
    gray_in = 4'b0000;
    repeat (10) tick();
    check("t4_pre_sticky", 32'(err_sticky), 32'd0);
    e0 = err_cnt;
    gray_in = 4'b0011;
    repeat (10) tick();
    check("t4_bin", 32'(bin_out), 32'h2);
    check("t4_step", 32'(step), 32'h2);
    check("t4_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("t4_sticky", 32'(err_sticky), 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    tick();
    check("t4_cleared", 32'(err_sticky), 32'd0);
    gray_in = 4'b0000; err_clear = 1'b1;
    repeat (3) tick();
    err_clear = 1'b0;
    repeat (5) tick();
    check("t4_set_wins", 32'(err_sticky), 32'd1);
    check("t4_bin2", 32'(bin_out), 32'h0);
    check("t4_step2", 32'(step), 32'hE);

    // Mid-walk reset, then release onto a new value
    for (int v = 1; v <= 7; v++) begin
      gray_in = to_gray(v);
      repeat (10) tick();
    end
    check("t6_bin_pre", 32'(bin_out), 32'h7);
    rst = 1'b1;
    #1;
    check("t6_rst_gsync", 32'(gray_sync), 32'd0);
    check("t6_rst_bin", 32'(bin_out), 32'd0);
    check("t6_rst_changed", 32'(changed), 32'd0);
    check("t6_rst_step", 32'(step), 32'd0);
    check("t6_rst_err", 32'(multi_bit_err), 32'd0);
    check("t6_rst_sticky", 32'(err_sticky), 32'd0);
    repeat (2) tick();
    gray_in = 4'b0101;
    tick();
    p0 = pulse_cnt;
    rst = 1'b0;
    repeat (10) tick();
    check("t6_bin", 32'(bin_out), 32'h6);
    check("t6_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("t6_gsync", 32'(gray_sync), 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
